// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter and its step timer.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int NUM_REQ = 3;
  localparam int LED_W   = 5;
  localparam int OWNER_W = 2;

  localparam logic [LED_W-1:0]   LED_RESET_PAT = 5'b00001;
  localparam logic [NUM_REQ-1:0] REQ_LSB       = 3'b001;

  function automatic int calc_step_cycles(input int clk_freq, input int step_ms);
    return clk_freq / 1000 * step_ms;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Free-running step timer: counts 0..STEP_CYCLES-1 and flags the last count as tick.
module led_step_timer #(
  parameter int STEP_CYCLES = 25000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Step counter, wraps after the last count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// Fixed-priority owner of the 5-LED bank with idle flowing light and hold-time limit.
// Optional build macro LED_ARB_PREEMPT_EN: a higher-priority request releases the current owner.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int STEP_MS        = 500,
  parameter int MAX_HOLD_STEPS = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_pattern,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [LED_W-1:0]         led,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       hold_expired
);

  localparam int STEP_CYCLES = calc_step_cycles(CLK_FREQ, STEP_MS);

  arb_state_e                      r_state;
  logic [LED_W-1:0]                r_idle_pat;
  logic [LED_W-1:0]                r_led;
  logic [NUM_REQ-1:0]              r_gnt;
  logic                            r_busy;
  logic [NUM_REQ-1:0]              r_hold_expired;
  logic [7:0]                      r_hold_cnt;
  logic [NUM_REQ-1:0]              r_mask;
  logic [OWNER_W-1:0]              r_owner;

  logic                            w_tick;
  logic [NUM_REQ-1:0]              w_eligible;
  logic                            w_any;
  logic [OWNER_W-1:0]              w_win_idx;
  logic [NUM_REQ-1:0]              w_win_oh;
  logic [NUM_REQ-1:0][LED_W-1:0]   w_pats;
  logic [LED_W-1:0]                w_owner_pat;
  logic                            w_owner_req;
  logic                            w_hold_done;
  logic                            w_preempt;

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .tick   (w_tick)
  );

  assign w_eligible  = req & ~r_mask;
  assign w_any       = |w_eligible;
  assign w_pats      = req_pattern;
  assign w_owner_pat = w_pats[r_owner];
  assign w_owner_req = req[r_owner];
  assign w_hold_done = (r_hold_cnt >= 8'(MAX_HOLD_STEPS));
  assign w_win_oh    = REQ_LSB << w_win_idx;

`ifdef LED_ARB_PREEMPT_EN
  logic [NUM_REQ-1:0] w_higher_mask;
  assign w_higher_mask = (REQ_LSB << r_owner) - REQ_LSB;
  assign w_preempt     = |(w_eligible & w_higher_mask);
`else
  assign w_preempt     = 1'b0;
`endif

  // Lowest-index eligible requester wins.
  always_comb begin
    if (w_eligible[0]) begin
      w_win_idx = 2'd0;
    end else if (w_eligible[1]) begin
      w_win_idx = 2'd1;
    end else begin
      w_win_idx = 2'd2;
    end
  end

  // Arbitration FSM with registered grant, LED drive and expiry pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state        <= IDLE;
      r_idle_pat     <= LED_RESET_PAT;
      r_led          <= LED_RESET_PAT;
      r_gnt          <= '0;
      r_busy         <= 1'b0;
      r_hold_expired <= '0;
      r_hold_cnt     <= 8'd0;
      r_mask         <= '0;
      r_owner        <= 2'd0;
    end else begin
      r_hold_expired <= '0;
      // A mask bit survives only while its request stays high.
      r_mask         <= r_mask & req;
      case (r_state)
        IDLE, GAP: begin
          r_hold_cnt <= 8'd0;
          if (w_any) begin
            r_gnt   <= w_win_oh;
            r_busy  <= 1'b1;
            r_owner <= w_win_idx;
            r_led   <= w_pats[w_win_idx];
            r_state <= OWNED;
          end else if ((r_state == IDLE) && w_tick) begin
            r_idle_pat <= {r_idle_pat[LED_W-2:0], r_idle_pat[LED_W-1]};
            r_led      <= {r_idle_pat[LED_W-2:0], r_idle_pat[LED_W-1]};
            r_state    <= IDLE;
          end else begin
            r_led   <= r_idle_pat;
            r_state <= IDLE;
          end
        end
        OWNED: begin
          if (!w_owner_req || w_hold_done || w_preempt) begin
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_led      <= r_idle_pat;
            r_hold_cnt <= 8'd0;
            r_state    <= GAP;
            // Release by the owner takes precedence over a coincident expiry.
            if (w_owner_req && w_hold_done) begin
              r_hold_expired <= r_gnt;
              r_mask         <= (r_mask & req) | r_gnt;
            end else begin
              r_hold_expired <= '0;
            end
          end else begin
            r_led <= w_owner_pat;
            if (w_tick && (r_hold_cnt != 8'hFF)) begin
              r_hold_cnt <= r_hold_cnt + 8'd1;
            end else begin
              r_hold_cnt <= r_hold_cnt;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_led   <= r_idle_pat;
        end
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign led          = r_led;
  assign busy         = r_busy;
  assign hold_expired = r_hold_expired;

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Owns the 5-LED bank and shares it between three pattern requesters using a req/gnt handshake with fixed priority.
- When no requester owns the bank, it runs the default flowing-light pattern, advancing one step per tick.
- Sits between the board LED pins and application blocks such as key/status/alarm indicators.
- Also enforces a maximum hold time so one requester cannot monopolise the bank.

Parameters:
- CLK_FREQ, 50000000, sys_clk frequency in Hz.
- STEP_MS, 500, step period in ms. STEP_CYCLES = CLK_FREQ/1000*STEP_MS; must be ≥2.
- MAX_HOLD_STEPS, 8, ticks a requester may hold the bank before forced release. Range 1..255.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- req  in  3  request per requester; bit 0 has highest priority; level-held while ownership is wanted.
- req_pattern  in  15  requester n drives bits [5n+4:5n].
- gnt  out  3  one-hot grant, registered.
- led  out  5  LED bank drive, registered; 1 = on.
- busy  out  1  high while any gnt bit is set.
- hold_expired  out  3  one-cycle pulse on bit n when requester n is forcibly released.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - state=IDLE; led=5'b00001; idle_pat=5'b00001; gnt=0; busy=0; hold_expired=0; step timer=0; hold counter=0; expiry mask=0.
- Step timer:
  - Counts 0..STEP_CYCLES-1 and wraps.
  - tick is high on the cycle where the count equals STEP_CYCLES-1.
  - Free-runs in every state.
- State IDLE:
  - led=idle_pat. On tick, idle_pat rotates left: {idle_pat[3:0],idle_pat[4]}; led follows on the same edge.
  - If any eligible request exists (req & ~mask), the lowest index wins. Sampled at edge N: gnt/busy high and led = that requester's pattern from edge N+1; state becomes OWNED.
  - If a tick and a grant happen on the same edge, the grant wins and idle_pat does not rotate.
- State OWNED:
  - led <= owner's req_pattern every cycle (one-cycle latency).
  - idle_pat is frozen.
  - The hold counter increments on each tick.
  - Owner deasserting req → next edge: gnt=0, state GAP.
  - The hold counter reaching MAX_HOLD_STEPS → next edge: gnt=0, hold_expired[owner] pulses, mask[owner] set, state GAP.
  - If req deassertion and expiry coincide, treat it as a normal release: no pulse, no mask.
- State GAP (exactly one cycle):
  - gnt=0; led=idle_pat; hold counter cleared; then IDLE.
  - Guarantees a dead cycle between owners.
- Mask:
  - mask[n] clears when req[n] is low for at least one cycle.
  - A masked requester is never granted.
- Non-owner requests in OWNED are ignored; they wait.
- req_pattern from non-owners is ignored.
- Widths: step timer is clog2(STEP_CYCLES) bits. Hold counter is 8 bits, saturating.

Optional Feature:
- LED_ARB_PREEMPT_EN
  - Defined: in OWNED, a lower-index eligible req forces release of the current owner on the next edge. No hold_expired pulse and no mask; goes through GAP, then the higher-priority requester is granted.
  - Undefined: no preemption; a grant ends only on release or expiry.

Decomposition:
- Shared package led_arb_pkg:
  - State enum {IDLE, OWNED, GAP}.
  - NUM_REQ=3, LED_W=5, LED_RESET_PAT=5'b00001.
  - Function computing STEP_CYCLES.
- Sub-module led_step_timer: parameter STEP_CYCLES; ports sys_clk, sys_rst, tick out. Reused by other timed blocks.

Test Plan (CLK_FREQ=1000, STEP_MS=4 → 4-cycle step, MAX_HOLD_STEPS=2):
- No req, 20 cycles after reset → led is 00001, 00010, 00100, 01000, 10000, 00001, changing every 4 cycles; gnt=0.
- req=3'b110 at edge N, req_pattern[9:5]=10101 → gnt=010 and led=10101 at N+1; busy=1.
- Owner 1 drops req → gnt=0 next edge; led shows frozen idle_pat for one GAP cycle; a pending req[2] is granted the cycle after.
- Owner 0 holds req for 3 ticks → gnt=0 after the 2nd tick plus 1 edge; hold_expired=001 for one cycle; req[0] not re-granted until it toggles low.
- sys_rst pulsed while gnt=100 → gnt=0, led=00001, busy=0 immediately, without waiting for a clock edge.
- LED_ARB_PREEMPT_EN defined, owner 2 active, req[0] rises → gnt 100→000 (GAP)→001 over two edges; hold_expired stays 0.
